// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: occupancy
// state, default widths and the control-field layout used by stage instances.
package pipe_pkg;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  // Default widths of payload, control field and event counters.
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CTRL_W = 16;
  localparam int DEFAULT_STAT_W = 16;

  // Control-field layout; an all-zero control word has no side effect.
  localparam int CTRL_ALU_OP_LSB   = 0;
  localparam int CTRL_ALU_OP_W     = 4;
  localparam int CTRL_MEM_READ     = 4;
  localparam int CTRL_MEM_WRITE    = 5;
  localparam int CTRL_WRITE_EN     = 6;
  localparam int CTRL_USES_RS      = 7;
  localparam int CTRL_USES_RT      = 8;
  localparam int CTRL_WRITE_REG_LSB = 9;
  localparam int CTRL_WRITE_REG_W  = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts qualifying cycles, sticks at all-ones,
// and is cleared only by reset.
module pipe_sat_counter #(
  parameter int STAT_W = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              INC,
  output logic [STAT_W-1:0] COUNT
);

  logic atMax;

  assign atMax = (COUNT == {STAT_W{1'b1}});

  // Count one per qualifying cycle, holding once the maximum is reached.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      COUNT <= '0;
    end else if (INC && !atMax) begin
      COUNT <= COUNT + STAT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: head + skid buffer with valid/ready on
// both sides, hazard STALL/FLUSH control and saturating debug counters.
// IN_READY depends only on registered occupancy, so backpressure never forms
// a combinational path from downstream back upstream.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int STAT_W = DEFAULT_STAT_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              STALL,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [STAT_W-1:0] STALL_COUNT,
  output logic [STAT_W-1:0] FLUSH_COUNT,
  output logic [STAT_W-1:0] BUBBLE_COUNT
);

  stateT             state;
  stateT             stateNext;
  logic [DATA_W-1:0] headData;
  logic [DATA_W-1:0] headDataNext;
  logic [CTRL_W-1:0] headCtrl;
  logic [CTRL_W-1:0] headCtrlNext;
  logic [DATA_W-1:0] skidData;
  logic [DATA_W-1:0] skidDataNext;
  logic [CTRL_W-1:0] skidCtrl;
  logic [CTRL_W-1:0] skidCtrlNext;
  logic              outValid;
  logic              inReady;
  logic              push;
  logic              pop;
  logic              stallEvent;
  logic              flushEvent;
  logic              bubbleEvent;

  assign outValid = (state != EMPTY);
  assign inReady  = (state != FULL);
  assign push     = IN_VALID & inReady;
  assign pop      = outValid & OUT_READY & ~STALL;

  assign OUT_VALID = outValid;
  assign IN_READY  = inReady;
  assign OUT_DATA  = outValid ? headData : '0;
  assign OUT_CTRL  = outValid ? headCtrl : '0;

  // Occupancy register; reset leaves the stage empty and ready.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Head and skid storage; vacated slots are always written back to zero.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      headData <= '0;
      headCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
    end else begin
      headData <= headDataNext;
      headCtrl <= headCtrlNext;
      skidData <= skidDataNext;
      skidCtrl <= skidCtrlNext;
    end
  end

  // Next occupancy and slot contents; FLUSH overrides push, pop and STALL.
  always_comb begin
    stateNext    = state;
    headDataNext = headData;
    headCtrlNext = headCtrl;
    skidDataNext = skidData;
    skidCtrlNext = skidCtrl;
    if (FLUSH) begin
      stateNext    = EMPTY;
      headDataNext = '0;
      headCtrlNext = '0;
      skidDataNext = '0;
      skidCtrlNext = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            stateNext    = ONE;
            headDataNext = IN_DATA;
            headCtrlNext = IN_CTRL;
          end
        end
        ONE: begin
          if (push && pop) begin
            headDataNext = IN_DATA;
            headCtrlNext = IN_CTRL;
          end else if (push) begin
            stateNext    = FULL;
            skidDataNext = IN_DATA;
            skidCtrlNext = IN_CTRL;
          end else if (pop) begin
            stateNext    = EMPTY;
            headDataNext = '0;
            headCtrlNext = '0;
          end
        end
        FULL: begin
          if (pop) begin
            stateNext    = ONE;
            headDataNext = skidData;
            headCtrlNext = skidCtrl;
            skidDataNext = '0;
            skidCtrlNext = '0;
          end
        end
        default: begin
          stateNext    = EMPTY;
          headDataNext = '0;
          headCtrlNext = '0;
          skidDataNext = '0;
          skidCtrlNext = '0;
        end
      endcase
    end
  end

  assign stallEvent  = STALL & outValid;
  assign flushEvent  = FLUSH & outValid;
  assign bubbleEvent = ~outValid & OUT_READY & ~STALL;

  pipe_sat_counter #(.STAT_W(STAT_W)) stallCounter (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .INC   (stallEvent),
    .COUNT (STALL_COUNT)
  );

  pipe_sat_counter #(.STAT_W(STAT_W)) flushCounter (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .INC   (flushEvent),
    .COUNT (FLUSH_COUNT)
  );

  pipe_sat_counter #(.STAT_W(STAT_W)) bubbleCounter (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .INC   (bubbleEvent),
    .COUNT (BUBBLE_COUNT)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a queue-based reference model checks every
// cycle, a table of directed vectors checks the documented scenarios, and a
// second instance with 2-bit counters covers saturation and async reset.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int CW = 16;
  localparam int SW = 16;
  localparam int SW2 = 2;
  localparam int SAT_MAX = 65535;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic          reset, flush, stall, inValid, outReady;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          inReadyW, outValidW;
  logic [DW-1:0] outDataW;
  logic [CW-1:0] outCtrlW;
  logic [SW-1:0] stallCountW, flushCountW, bubbleCountW;

  logic           reset2, flush2, stall2, inValid2, outReady2;
  logic [DW-1:0]  inData2;
  logic [CW-1:0]  inCtrl2;
  logic           inReady2, outValid2;
  logic [DW-1:0]  outData2;
  logic [CW-1:0]  outCtrl2;
  logic [SW2-1:0] stallCount2, flushCount2, bubbleCount2;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .STAT_W(SW)) dut (
    .CLOCK(CLOCK), .RESET(reset), .FLUSH(flush), .STALL(stall),
    .IN_VALID(inValid), .IN_READY(inReadyW), .IN_DATA(inData), .IN_CTRL(inCtrl),
    .OUT_VALID(outValidW), .OUT_READY(outReady), .OUT_DATA(outDataW), .OUT_CTRL(outCtrlW),
    .STALL_COUNT(stallCountW), .FLUSH_COUNT(flushCountW), .BUBBLE_COUNT(bubbleCountW)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .STAT_W(SW2)) dut2 (
    .CLOCK(CLOCK), .RESET(reset2), .FLUSH(flush2), .STALL(stall2),
    .IN_VALID(inValid2), .IN_READY(inReady2), .IN_DATA(inData2), .IN_CTRL(inCtrl2),
    .OUT_VALID(outValid2), .OUT_READY(outReady2), .OUT_DATA(outData2), .OUT_CTRL(outCtrl2),
    .STALL_COUNT(stallCount2), .FLUSH_COUNT(flushCount2), .BUBBLE_COUNT(bubbleCount2)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entryT;

  entryT mQ[$];
  int    mStall, mFlush, mBubble;

  typedef struct {
    logic          flush;
    logic          stall;
    logic          inValid;
    logic [DW-1:0] data;
    logic          outReady;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expReady;
  } vecT;

  vecT vecs[18];

  function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 16'hA5A5;
  endfunction

  function automatic vecT mkVec(input logic fl, input logic st, input logic iv,
                                input logic [DW-1:0] d, input logic orr,
                                input logic ev, input logic [DW-1:0] ed, input logic er);
    vecT v;
    v.flush = fl; v.stall = st; v.inValid = iv; v.data = d; v.outReady = orr;
    v.expValid = ev; v.expData = ed; v.expReady = er;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
  endtask

  function automatic int satInc(input int v);
    return (v < SAT_MAX) ? v + 1 : v;
  endfunction

  // Compare the DUT against the model's view of the current cycle.
  task automatic checkModel();
    entryT h;
    logic mValid;
    mValid = (mQ.size() != 0);
    h.data = '0; h.ctrl = '0;
    if (mValid) h = mQ[0];
    checkOutput("model OUT_VALID", 64'(outValidW), 64'(mValid));
    checkOutput("model IN_READY", 64'(inReadyW), 64'(mQ.size() < 2));
    checkOutput("model OUT_DATA", outDataW, h.data);
    checkOutput("model OUT_CTRL", 64'(outCtrlW), 64'(h.ctrl));
    checkOutput("model STALL_COUNT", 64'(stallCountW), 64'(mStall));
    checkOutput("model FLUSH_COUNT", 64'(flushCountW), 64'(mFlush));
    checkOutput("model BUBBLE_COUNT", 64'(bubbleCountW), 64'(mBubble));
  endtask

  // Drive one cycle of inputs, check, clock, and advance the model.
  task automatic applyStimulus(input logic fl, input logic st, input logic iv,
                               input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic orr);
    logic  mValid, doPush, doPop;
    entryT e;
    flush = fl; stall = st; inValid = iv; inData = d; inCtrl = c; outReady = orr;
    checkModel();
    mValid = (mQ.size() != 0);
    doPush = iv && (mQ.size() < 2);
    doPop  = mValid && orr && !st;
    @(posedge CLOCK);
    if (st && mValid) mStall = satInc(mStall);
    if (fl && mValid) mFlush = satInc(mFlush);
    if (!mValid && orr && !st) mBubble = satInc(mBubble);
    if (fl) begin
      mQ.delete();
    end else begin
      if (doPop) void'(mQ.pop_front());
      if (doPush) begin
        e.data = d; e.ctrl = c;
        mQ.push_back(e);
      end
    end
    @(negedge CLOCK);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; stall = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inData = '0; inCtrl = '0;
    reset2 = 1'b0; flush2 = 1'b0; stall2 = 1'b0; inValid2 = 1'b0; outReady2 = 1'b0;
    inData2 = '0; inCtrl2 = '0;
    mQ.delete(); mStall = 0; mFlush = 0; mBubble = 0;

    vecs[0]  = mkVec(0, 0, 1, 64'h11, 1, 1, 64'h11, 1);
    vecs[1]  = mkVec(0, 0, 1, 64'h22, 1, 1, 64'h22, 1);
    vecs[2]  = mkVec(0, 0, 1, 64'h33, 1, 1, 64'h33, 1);
    vecs[3]  = mkVec(0, 0, 0, 64'h0,  1, 0, 64'h0,  1);
    vecs[4]  = mkVec(0, 0, 1, 64'hA,  0, 1, 64'hA,  1);
    vecs[5]  = mkVec(0, 0, 1, 64'hB,  0, 1, 64'hA,  0);
    vecs[6]  = mkVec(0, 0, 1, 64'hC,  0, 1, 64'hA,  0);
    vecs[7]  = mkVec(0, 0, 1, 64'hC,  1, 1, 64'hB,  1);
    vecs[8]  = mkVec(0, 0, 1, 64'hC,  1, 1, 64'hC,  1);
    vecs[9]  = mkVec(0, 0, 0, 64'h0,  1, 0, 64'h0,  1);
    vecs[10] = mkVec(0, 0, 1, 64'h5,  1, 1, 64'h5,  1);
    vecs[11] = mkVec(0, 1, 1, 64'h6,  1, 1, 64'h5,  0);
    vecs[12] = mkVec(0, 1, 0, 64'h0,  1, 1, 64'h5,  0);
    vecs[13] = mkVec(0, 1, 0, 64'h0,  1, 1, 64'h5,  0);
    vecs[14] = mkVec(0, 0, 0, 64'h0,  1, 1, 64'h6,  1);
    vecs[15] = mkVec(0, 0, 1, 64'h8,  0, 1, 64'h6,  0);
    vecs[16] = mkVec(1, 1, 1, 64'h7,  1, 0, 64'h0,  1);
    vecs[17] = mkVec(0, 0, 0, 64'h0,  0, 0, 64'h0,  1);

    repeat (2) @(negedge CLOCK);
    checkOutput("reset OUT_VALID", 64'(outValidW), 64'(0));
    checkOutput("reset OUT_DATA", outDataW, 64'(0));
    checkOutput("reset IN_READY", 64'(inReadyW), 64'(1));
    checkOutput("reset STALL_COUNT", 64'(stallCountW), 64'(0));
    checkOutput("reset FLUSH_COUNT", 64'(flushCountW), 64'(0));
    checkOutput("reset BUBBLE_COUNT", 64'(bubbleCountW), 64'(0));
    reset = 1'b1;
    reset2 = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("idle BUBBLE_COUNT", 64'(bubbleCountW), 64'(10));

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].stall, vecs[i].inValid, vecs[i].data,
                    ctrlOf(vecs[i].data), vecs[i].outReady);
      checkOutput($sformatf("vec%0d OUT_VALID", i), 64'(outValidW), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d OUT_DATA", i), outDataW, vecs[i].expData);
      checkOutput($sformatf("vec%0d OUT_CTRL", i), 64'(outCtrlW),
                  vecs[i].expValid ? 64'(ctrlOf(vecs[i].expData)) : 64'(0));
      checkOutput($sformatf("vec%0d IN_READY", i), 64'(inReadyW), 64'(vecs[i].expReady));
      if (i == 13) checkOutput("stall STALL_COUNT", 64'(stallCountW), 64'(3));
      if (i == 16) checkOutput("flush FLUSH_COUNT", 64'(flushCountW), 64'(1));
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0, {$urandom, $urandom},
                    16'($urandom), $urandom_range(0, 3) != 0);
    end
    applyStimulus(0, 0, 0, '0, '0, 1);

    inValid2 = 1'b1; inData2 = 64'h1; inCtrl2 = 16'h1; outReady2 = 1'b0;
    @(posedge CLOCK); @(negedge CLOCK);
    stall2 = 1'b1; outReady2 = 1'b1; inData2 = 64'h2; inCtrl2 = 16'h2;
    repeat (5) begin @(posedge CLOCK); @(negedge CLOCK); end
    checkOutput("sat STALL_COUNT", 64'(stallCount2), 64'(3));
    checkOutput("sat OUT_VALID", 64'(outValid2), 64'(1));
    checkOutput("sat OUT_DATA", outData2, 64'h1);
    checkOutput("sat IN_READY full", 64'(inReady2), 64'(0));
    stall2 = 1'b0; inValid2 = 1'b0; outReady2 = 1'b0;
    #2 reset2 = 1'b0;
    #1;
    checkOutput("async OUT_VALID", 64'(outValid2), 64'(0));
    checkOutput("async OUT_DATA", outData2, 64'(0));
    checkOutput("async IN_READY", 64'(inReady2), 64'(1));
    checkOutput("async STALL_COUNT", 64'(stallCount2), 64'(0));
    #1 reset2 = 1'b1;
    inValid2 = 1'b1; inData2 = 64'h9; inCtrl2 = 16'h9;
    @(posedge CLOCK); @(negedge CLOCK);
    inValid2 = 1'b0;
    checkOutput("post-reset OUT_VALID", 64'(outValid2), 64'(1));
    checkOutput("post-reset OUT_DATA", outData2, 64'h9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
